fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 36 +++
 rtl/fetch_stage.sv | 213 +++++++++++++++++++++
 tb/tb_fetch_stage.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory request/response bus between the fetch stage and the
// instruction memory (or cache).
//
//   inst_req      fetch -> mem   request valid
//   inst_addr     fetch -> mem   request address (word aligned when inst_req)
//   inst_addr_ok  mem -> fetch   request accepted when inst_req && inst_addr_ok
//   inst_data_ok  mem -> fetch   one in-order response per accepted request
//   inst_rdata    mem -> fetch   instruction word, valid with inst_data_ok
//
// master: fetch-stage side, slave: memory side.
// ---------------------------------------------------------------------------
interface fetch_stage_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage: generates fetch addresses, runs the one-deep
// instruction-memory request FSM (IDLE / WAIT / CANCEL) and holds the fetched
// instruction in a one-entry output slot offered to decode.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   ds_allowin           decode accepts the offered slot this cycle
//   br_taken, br_target  branch redirect from decode (single-cycle pulse)
//   ds_is_branch         decode currently holds a branch/jump
//   flush, flush_pc      exception/ERET redirect (single-cycle pulse)
//   imem                 instruction-memory bus (fetch_stage_if.master)
//   fs_valid, fs_pc, fs_inst                     offered slot
//   fs_ex, fs_exccode, fs_bd, fs_badvaddr        slot exception fields
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ds_allowin,
  input  logic                 br_taken,
  input  logic [31:0]          br_target,
  input  logic                 ds_is_branch,
  input  logic                 flush,
  input  logic [31:0]          flush_pc,
  fetch_stage_if.master        imem,
  output logic                 fs_valid,
  output logic [31:0]          fs_pc,
  output logic [31:0]          fs_inst,
  output logic                 fs_ex,
  output logic [4:0]           fs_exccode,
  output logic                 fs_bd,
  output logic [31:0]          fs_badvaddr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] CANCEL = 2'd2;

  localparam logic [4:0] EXC_ADEL = 5'h04;

  logic [1:0]  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;              // next address to request
  logic [31:0] req_pc_reg, req_pc_next;      // address of the outstanding request
  logic [31:0] ds_pc_reg, ds_pc_next;        // PC of the instruction now in decode
  logic        pend_valid_reg, pend_valid_next;
  logic [31:0] pend_pc_reg, pend_pc_next;
  logic        halt_reg, halt_next;
  logic        slot_valid_reg, slot_valid_next;
  logic [31:0] slot_pc_reg, slot_pc_next;
  logic [31:0] slot_inst_reg, slot_inst_next;
  logic        slot_ex_reg, slot_ex_next;
  logic        slot_bd_reg, slot_bd_next;
  logic [31:0] slot_badvaddr_reg, slot_badvaddr_next;

  logic        slot_free;
  logic        pc_misaligned;
  logic        req;
  logic        fire;
  logic [31:0] ds_addr;
  logic        ds_in_slot, ds_in_flight, ds_requesting;
  logic        br_now, br_defer;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        drop_wait, drop_fire, clear_slot;
  logic        load_data, load_ex;

  always_comb begin
    slot_free     = !slot_valid_reg || ds_allowin;
    pc_misaligned = pc_reg[1:0] != 2'b00;
    // Gated by resetn so the request is low for the whole time reset is held.
    req  = resetn && (state_reg == IDLE) && slot_free && !pc_misaligned && !halt_reg;
    fire = req && imem.inst_addr_ok;

    // The delay slot is the word after the branch that decode holds. A taken
    // branch only redirects once that word has been requested; before then
    // the target is parked in the pending register.
    ds_addr       = ds_pc_reg + 32'd4;
    ds_in_slot    = slot_valid_reg && (slot_pc_reg == ds_addr);
    ds_in_flight  = (state_reg == WAIT) && (req_pc_reg == ds_addr);
    ds_requesting = fire && (pc_reg == ds_addr);
    br_now   = br_taken && !flush && (ds_in_slot || ds_in_flight || ds_requesting);
    br_defer = br_taken && !flush && !br_now;

    redirect    = flush || br_now;
    redirect_pc = flush ? flush_pc : br_target;
    // What a redirect throws away: anything fetched past the delay slot.
    drop_wait  = flush || (br_now && !ds_in_flight);
    drop_fire  = flush || (br_now && !ds_requesting);
    clear_slot = flush || (br_now && !ds_in_slot);

    load_data = (state_reg == WAIT) && imem.inst_data_ok && !drop_wait;
    load_ex   = (state_reg == IDLE) && slot_free && pc_misaligned && !halt_reg && !redirect;

    state_next         = state_reg;
    pc_next            = pc_reg;
    req_pc_next        = req_pc_reg;
    ds_pc_next         = ds_pc_reg;
    pend_valid_next    = pend_valid_reg;
    pend_pc_next       = pend_pc_reg;
    halt_next          = halt_reg;
    slot_valid_next    = slot_valid_reg;
    slot_pc_next       = slot_pc_reg;
    slot_inst_next     = slot_inst_reg;
    slot_ex_next       = slot_ex_reg;
    slot_bd_next       = slot_bd_reg;
    slot_badvaddr_next = slot_badvaddr_reg;

    case (state_reg)
      IDLE: begin
        if (fire) begin
          state_next  = drop_fire ? CANCEL : WAIT;
          req_pc_next = pc_reg;
        end
      end
      WAIT: begin
        if (imem.inst_data_ok) state_next = IDLE;
        else if (drop_wait)    state_next = CANCEL;
      end
      CANCEL: begin
        if (imem.inst_data_ok) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (redirect)  pc_next = redirect_pc;
    else if (fire) pc_next = pend_valid_reg ? pend_pc_reg : pc_reg + 32'd4;

    if (redirect) begin
      pend_valid_next = 1'b0;
    end else if (br_defer) begin
      pend_valid_next = 1'b1;
      pend_pc_next    = br_target;
    end else if (fire) begin
      pend_valid_next = 1'b0;
    end

    if (flush)        halt_next = 1'b0;
    else if (load_ex) halt_next = 1'b1;

    if (slot_valid_reg && ds_allowin) ds_pc_next = slot_pc_reg;

    // A request is only issued into a free slot, so the slot is always empty
    // while a response is awaited and load_data never collides with contents.
    if (load_data) begin
      slot_valid_next    = 1'b1;
      slot_pc_next       = req_pc_reg;
      slot_inst_next     = imem.inst_rdata;
      slot_ex_next       = 1'b0;
      slot_bd_next       = ds_is_branch;
      slot_badvaddr_next = 32'h0;
    end else if (clear_slot) begin
      slot_valid_next = 1'b0;
      slot_ex_next    = 1'b0;
      slot_bd_next    = 1'b0;
    end else if (load_ex) begin
      slot_valid_next    = 1'b1;
      slot_pc_next       = pc_reg;
      slot_inst_next     = 32'h0;
      slot_ex_next       = 1'b1;
      slot_bd_next       = ds_is_branch;
      slot_badvaddr_next = pc_reg;
    end else if (ds_allowin) begin
      slot_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg         <= IDLE;
      pc_reg            <= RESET_PC;
      req_pc_reg        <= 32'h0;
      ds_pc_reg         <= 32'h0;
      pend_valid_reg    <= 1'b0;
      pend_pc_reg       <= 32'h0;
      halt_reg          <= 1'b0;
      slot_valid_reg    <= 1'b0;
      slot_pc_reg       <= 32'h0;
      slot_inst_reg     <= 32'h0;
      slot_ex_reg       <= 1'b0;
      slot_bd_reg       <= 1'b0;
      slot_badvaddr_reg <= 32'h0;
    end else begin
      state_reg         <= state_next;
      pc_reg            <= pc_next;
      req_pc_reg        <= req_pc_next;
      ds_pc_reg         <= ds_pc_next;
      pend_valid_reg    <= pend_valid_next;
      pend_pc_reg       <= pend_pc_next;
      halt_reg          <= halt_next;
      slot_valid_reg    <= slot_valid_next;
      slot_pc_reg       <= slot_pc_next;
      slot_inst_reg     <= slot_inst_next;
      slot_ex_reg       <= slot_ex_next;
      slot_bd_reg       <= slot_bd_next;
      slot_badvaddr_reg <= slot_badvaddr_next;
    end
  end

  assign imem.inst_req  = req;
  assign imem.inst_addr = pc_reg;

  assign fs_valid    = slot_valid_reg;
  assign fs_pc       = slot_pc_reg;
  assign fs_inst     = slot_inst_reg;
  assign fs_ex       = slot_ex_reg;
  assign fs_exccode  = slot_ex_reg ? EXC_ADEL : 5'h00;
  assign fs_bd       = slot_bd_reg;
  assign fs_badvaddr = slot_badvaddr_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. The bench plays both decode and instruction
// memory cycle by cycle: inputs change on the falling edge and outputs are
// checked 1 ns later, so each row describes what is seen during one cycle.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ds_allowin, br_taken, ds_is_branch, flush;
  logic [31:0] br_target, flush_pc;
  logic        fs_valid, fs_ex, fs_bd;
  logic [31:0] fs_pc, fs_inst, fs_badvaddr;
  logic [4:0]  fs_exccode;

  fetch_stage_if imem();

  fetch_stage #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ds_allowin   (ds_allowin),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .ds_is_branch (ds_is_branch),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .imem         (imem),
    .fs_valid     (fs_valid),
    .fs_pc        (fs_pc),
    .fs_inst      (fs_inst),
    .fs_ex        (fs_ex),
    .fs_exccode   (fs_exccode),
    .fs_bd        (fs_bd),
    .fs_badvaddr  (fs_badvaddr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        allowin, aok, dok;
    logic [31:0] rdata;
    logic        br;
    logic [31:0] tgt;
    logic        isbr;
    logic        req_e;
    logic [31:0] addr_e;
    logic        v_e;
    logic [31:0] pc_e, inst_e;
    logic        bd_e;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mkv(input logic a, input logic ao, input logic dk,
                               input logic [31:0] rd, input logic br,
                               input logic [31:0] tgt, input logic isbr,
                               input logic re, input logic [31:0] ae,
                               input logic ve, input logic [31:0] pe,
                               input logic [31:0] ie, input logic be);
    vec_t v;
    v.allowin = a;  v.aok = ao;  v.dok = dk;  v.rdata = rd;
    v.br = br;      v.tgt = tgt; v.isbr = isbr;
    v.req_e = re;   v.addr_e = ae; v.v_e = ve;
    v.pc_e = pe;    v.inst_e = ie; v.bd_e = be;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus with no branch; leaves reset released.
  task automatic drv(input logic a, input logic ao, input logic dk,
                     input logic [31:0] rd, input logic fl, input logic [31:0] fpc);
    @(negedge clk);
    resetn = 1'b1;
    ds_allowin = a;  imem.inst_addr_ok = ao;  imem.inst_data_ok = dk;
    imem.inst_rdata = rd;  flush = fl;  flush_pc = fpc;
    br_taken = 1'b0;  br_target = 32'h0;  ds_is_branch = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    ds_allowin = 1'b0;  br_taken = 1'b0;  br_target = 32'h0;  ds_is_branch = 1'b0;
    flush = 1'b0;  flush_pc = 32'h0;
    imem.inst_addr_ok = 1'b0;  imem.inst_data_ok = 1'b0;  imem.inst_rdata = 32'h0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Sequential fetch, decode stall, deferred branch through its delay slot.
    vecs[0]  = mkv(1,1,0,32'h0,       0,32'h0,1'b0, 1,32'hBFC00000, 0,32'h0,32'h0,0);
    vecs[1]  = mkv(1,1,1,32'h11111111,0,32'h0,1'b0, 0,32'h0,        0,32'h0,32'h0,0);
    vecs[2]  = mkv(1,1,0,32'h0,       0,32'h0,1'b0, 1,32'hBFC00004, 1,32'hBFC00000,32'h11111111,0);
    vecs[3]  = mkv(1,1,1,32'h22222222,0,32'h0,1'b0, 0,32'h0,        0,32'h0,32'h0,0);
    vecs[4]  = mkv(1,1,0,32'h0,       0,32'h0,1'b0, 1,32'hBFC00008, 1,32'hBFC00004,32'h22222222,0);
    vecs[5]  = mkv(1,1,1,32'h33333333,0,32'h0,1'b0, 0,32'h0,        0,32'h0,32'h0,0);
    for (int i = 6; i <= 10; i++)
      vecs[i] = mkv(0,1,0,32'h0,      0,32'h0,1'b0, 0,32'h0,        1,32'hBFC00008,32'h33333333,0);
    vecs[11] = mkv(1,1,0,32'h0,       0,32'h0,1'b0, 1,32'hBFC0000C, 1,32'hBFC00008,32'h33333333,0);
    vecs[12] = mkv(1,1,1,32'h44444444,0,32'h0,1'b0, 0,32'h0,        0,32'h0,32'h0,0);
    vecs[13] = mkv(0,1,0,32'h0,       0,32'h0,1'b0, 0,32'h0,        1,32'hBFC0000C,32'h44444444,0);
    vecs[14] = mkv(1,0,0,32'h0,       0,32'h0,1'b0, 1,32'hBFC00010, 1,32'hBFC0000C,32'h44444444,0);
    vecs[15] = mkv(0,0,0,32'h0,       1,32'h80001000,1'b1, 1,32'hBFC00010, 0,32'h0,32'h0,0);
    vecs[16] = mkv(0,1,0,32'h0,       0,32'h0,1'b1, 1,32'hBFC00010, 0,32'h0,32'h0,0);
    vecs[17] = mkv(0,1,1,32'h55555555,0,32'h0,1'b1, 0,32'h0,        0,32'h0,32'h0,0);
    vecs[18] = mkv(1,1,0,32'h0,       0,32'h0,1'b1, 1,32'h80001000, 1,32'hBFC00010,32'h55555555,1);
    vecs[19] = mkv(1,1,1,32'h66666666,0,32'h0,1'b0, 0,32'h0,        0,32'h0,32'h0,0);
    vecs[20] = mkv(1,0,0,32'h0,       0,32'h0,1'b0, 1,32'h80001004, 1,32'h80001000,32'h66666666,0);

    // Reset values, checked while reset is held.
    resetn = 1'b1;
    #1;
    do_reset();
    chk("rst.req",   32'(imem.inst_req), 32'h0);
    chk("rst.valid", 32'(fs_valid),      32'h0);
    chk("rst.pc",    fs_pc,              32'h0);
    chk("rst.inst",  fs_inst,            32'h0);
    chk("rst.ex",    32'(fs_ex),         32'h0);
    chk("rst.bd",    32'(fs_bd),         32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      resetn = 1'b1;
      ds_allowin = vecs[i].allowin;
      imem.inst_addr_ok = vecs[i].aok;
      imem.inst_data_ok = vecs[i].dok;
      imem.inst_rdata = vecs[i].rdata;
      br_taken = vecs[i].br;  br_target = vecs[i].tgt;  ds_is_branch = vecs[i].isbr;
      flush = 1'b0;  flush_pc = 32'h0;
      #1;
      $display("vec %0d: req=%b addr=%h valid=%b pc=%h inst=%h bd=%b",
               i, imem.inst_req, imem.inst_addr, fs_valid, fs_pc, fs_inst, fs_bd);
      chk($sformatf("v%0d.req", i),   32'(imem.inst_req), 32'(vecs[i].req_e));
      if (vecs[i].req_e) chk($sformatf("v%0d.addr", i), imem.inst_addr, vecs[i].addr_e);
      chk($sformatf("v%0d.valid", i), 32'(fs_valid), 32'(vecs[i].v_e));
      if (vecs[i].v_e) begin
        chk($sformatf("v%0d.pc", i),   fs_pc,      vecs[i].pc_e);
        chk($sformatf("v%0d.inst", i), fs_inst,    vecs[i].inst_e);
        chk($sformatf("v%0d.bd", i),   32'(fs_bd), 32'(vecs[i].bd_e));
      end
    end

    // Flush while waiting; the response 3 cycles later is dropped.
    do_reset();
    drv(1,1,0,32'h0,0,32'h0);
    chk("fl.req0", 32'(imem.inst_req), 32'h1);
    drv(1,0,0,32'h0,1,32'hBFC00380);
    chk("fl.req1", 32'(imem.inst_req), 32'h0);
    drv(1,0,0,32'h0,0,32'h0);
    chk("fl.req2", 32'(imem.inst_req), 32'h0);
    drv(1,0,0,32'h0,0,32'h0);
    chk("fl.req3", 32'(imem.inst_req), 32'h0);
    drv(1,0,1,32'hDEADBEEF,0,32'h0);
    chk("fl.req4", 32'(imem.inst_req), 32'h0);
    drv(1,1,0,32'h0,0,32'h0);
    $display("flush seq: req=%b addr=%h valid=%b", imem.inst_req, imem.inst_addr, fs_valid);
    chk("fl.valid5", 32'(fs_valid),      32'h0);
    chk("fl.req5",   32'(imem.inst_req), 32'h1);
    chk("fl.addr5",  imem.inst_addr,     32'hBFC00380);
    drv(0,0,1,32'h12345678,0,32'h0);
    drv(0,0,0,32'h0,0,32'h0);
    chk("fl.valid7", 32'(fs_valid), 32'h1);
    chk("fl.pc7",    fs_pc,         32'hBFC00380);
    chk("fl.inst7",  fs_inst,       32'h12345678);
    chk("fl.ex7",    32'(fs_ex),    32'h0);

    // Misaligned flush target: no request, AdEL slot, halt until next flush.
    do_reset();
    drv(0,0,0,32'h0,1,32'h80000002);
    drv(0,1,0,32'h0,0,32'h0);
    chk("mis.req1", 32'(imem.inst_req), 32'h0);
    drv(0,1,0,32'h0,0,32'h0);
    $display("misaligned seq: valid=%b ex=%b code=%h badv=%h", fs_valid, fs_ex, fs_exccode, fs_badvaddr);
    chk("mis.req2",  32'(imem.inst_req), 32'h0);
    chk("mis.valid", 32'(fs_valid),      32'h1);
    chk("mis.ex",    32'(fs_ex),         32'h1);
    chk("mis.code",  32'(fs_exccode),    32'h4);
    chk("mis.badv",  fs_badvaddr,        32'h80000002);
    chk("mis.pc",    fs_pc,              32'h80000002);
    chk("mis.inst",  fs_inst,            32'h0);
    drv(1,1,0,32'h0,0,32'h0);
    chk("mis.req3",  32'(imem.inst_req), 32'h0);
    drv(1,1,0,32'h0,1,32'h80000100);
    chk("mis.req4",  32'(imem.inst_req), 32'h0);
    chk("mis.valid4", 32'(fs_valid),     32'h0);
    drv(1,0,0,32'h0,0,32'h0);
    chk("mis.req5",  32'(imem.inst_req), 32'h1);
    chk("mis.addr5", imem.inst_addr,     32'h80000100);

    // Reset pulsed while a request is outstanding.
    do_reset();
    drv(1,1,0,32'h0,0,32'h0);
    drv(1,1,0,32'h0,0,32'h0);
    chk("rw.req1", 32'(imem.inst_req), 32'h0);
    resetn = 1'b0;
    #1;
    chk("rw.req_rst",   32'(imem.inst_req), 32'h0);
    chk("rw.valid_rst", 32'(fs_valid),      32'h0);
    @(posedge clk);
    drv(1,1,0,32'h0,0,32'h0);
    $display("reset-in-wait seq: req=%b addr=%h", imem.inst_req, imem.inst_addr);
    chk("rw.req2",  32'(imem.inst_req), 32'h1);
    chk("rw.addr2", imem.inst_addr,     32'hBFC00000);
    drv(0,0,1,32'hAAAA5555,0,32'h0);
    drv(0,0,0,32'h0,0,32'h0);
    chk("rw.valid4", 32'(fs_valid), 32'h1);
    chk("rw.pc4",    fs_pc,         32'hBFC00000);
    chk("rw.inst4",  fs_inst,       32'hAAAA5555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
